// File: rtl/output_accum_tile_buffer.sv
// Output stage of the systolic array: captures a result tile, folds it into a signed
// accumulator tile (overwrite or add, optional saturation) and drains it row by row.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; first load beat or drain request accepted
// S_LOAD  | collecting capture beats into the staging tile
// S_FULL  | staging tile complete, waiting for acc_go
// S_ACC   | one staging row folded into the accumulator per cycle
// S_DRAIN | accumulator rows presented on the valid/ready stream
module output_accum_tile_buffer #(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter int AW   = 40,
    parameter int SKEW = 0,
    parameter int SAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic [N*DW-1:0] in_res,
    output logic            load_ready,
    output logic            tile_full,
    input  logic            acc_go,
    input  logic            acc_first,
    input  logic            out_start,
    input  logic            out_clear,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*AW-1:0] out_res,
    output logic            out_last,
    output logic            busy,
    output logic            cmd_err
);

    localparam int BEATS = (SKEW != 0) ? 2 * N - 1 : N;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FULL, S_ACC, S_DRAIN} state_t;

    state_t                state;
    logic signed [DW-1:0]  stage [N][N];
    logic signed [AW-1:0]  acc   [N][N];
    logic [BW-1:0]         beat;
    logic [RW-1:0]         row;
    logic                  first_q;
    logic                  clear_q;
    logic                  load_fire;
    logic                  last_beat;
    logic                  last_row;
    logic [BW:0]           cap_row [N];
    logic                  cap_en  [N];
    logic signed [AW-1:0]  acc_next [N];

    function automatic logic signed [AW-1:0] fold(input logic signed [AW-1:0] a,
                                                  input logic signed [DW-1:0] s,
                                                  input logic                 first);
        logic signed [AW:0] s_ext;
        logic signed [AW:0] sum;
        s_ext = (AW+1)'(s);
        sum   = (AW+1)'(a) + s_ext;
        if (first)
            return s_ext[AW-1:0];
        // One extra bit is enough to see overflow: the top two bits disagree.
        if (SAT != 0 && sum[AW] != sum[AW-1])
            return sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return sum[AW-1:0];
    endfunction

    assign load_ready = (state == S_IDLE) || (state == S_LOAD);
    assign tile_full  = (state == S_FULL);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DRAIN);
    assign load_fire  = load_valid && load_ready;
    assign last_beat  = (beat == BW'(BEATS - 1));
    assign last_row   = (row == RW'(N - 1));
    assign out_last   = (state == S_DRAIN) && last_row;

    // Diagonal capture: lane c of beat b belongs to row b-c; underflow wraps high and fails the bound.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            cap_row[c] = {1'b0, beat} - ((SKEW != 0) ? (BW+1)'(c) : '0);
            cap_en[c]  = cap_row[c] < (BW+1)'(N);
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) begin
            acc_next[c]          = fold(acc[row][c], stage[row][c], first_q);
            out_res[c*AW +: AW]  = acc[row][c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            row     <= '0;
            first_q <= 1'b0;
            clear_q <= 1'b0;
            cmd_err <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    stage[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
            end
        end else begin
            cmd_err <= (load_valid && !load_ready)
                    || (acc_go && state != S_FULL)
                    || (out_start && (state != S_IDLE || load_valid));

            if (load_fire) begin
                for (int c = 0; c < N; c++) begin
                    if (cap_en[c])
                        stage[cap_row[c][RW-1:0]][c] <= in_res[c*DW +: DW];
                end
            end

            case (state)
                S_IDLE, S_LOAD: begin
                    if (load_fire) begin
                        if (last_beat) begin
                            state <= S_FULL;
                            beat  <= '0;
                        end else begin
                            state <= S_LOAD;
                            beat  <= beat + 1'b1;
                        end
                    end else if (state == S_IDLE && out_start) begin
                        state   <= S_DRAIN;
                        row     <= '0;
                        clear_q <= out_clear;
                    end
                end
                S_FULL: begin
                    if (acc_go) begin
                        state   <= S_ACC;
                        row     <= '0;
                        first_q <= acc_first;
                    end
                end
                S_ACC: begin
                    for (int c = 0; c < N; c++)
                        acc[row][c] <= acc_next[c];
                    if (last_row) begin
                        state <= S_IDLE;
                        beat  <= '0;
                        row   <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (last_row) begin
                            state <= S_IDLE;
                            row   <= '0;
                            if (clear_q) begin
                                for (int r = 0; r < N; r++)
                                    for (int c = 0; c < N; c++)
                                        acc[r][c] <= '0;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_accum_tile_buffer.sv
// Bench for output_accum_tile_buffer: four instances (plain, skewed, saturating, wrapping)
// checked against a longint model through a drain scoreboard.
module tb_output_accum_tile_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   load_valid = '0;
    logic [3:0]   acc_go     = '0;
    logic [3:0]   acc_first  = '0;
    logic [3:0]   out_start  = '0;
    logic [3:0]   out_clear  = '0;
    logic [3:0]   out_ready  = '0;
    logic [127:0] in_res [4];
    wire  [3:0]   load_ready, tile_full, out_valid, out_last, busy, cmd_err;
    wire  [159:0] res0, res1;
    wire  [127:0] res2, res3;

    output_accum_tile_buffer #(.N(4), .DW(32), .AW(40), .SKEW(0), .SAT(1)) u_main (
        .clk(clk), .rst(rst), .load_valid(load_valid[0]), .in_res(in_res[0]),
        .load_ready(load_ready[0]), .tile_full(tile_full[0]), .acc_go(acc_go[0]),
        .acc_first(acc_first[0]), .out_start(out_start[0]), .out_clear(out_clear[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_res(res0),
        .out_last(out_last[0]), .busy(busy[0]), .cmd_err(cmd_err[0]));

    output_accum_tile_buffer #(.N(4), .DW(32), .AW(40), .SKEW(1), .SAT(1)) u_skew (
        .clk(clk), .rst(rst), .load_valid(load_valid[1]), .in_res(in_res[1]),
        .load_ready(load_ready[1]), .tile_full(tile_full[1]), .acc_go(acc_go[1]),
        .acc_first(acc_first[1]), .out_start(out_start[1]), .out_clear(out_clear[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_res(res1),
        .out_last(out_last[1]), .busy(busy[1]), .cmd_err(cmd_err[1]));

    output_accum_tile_buffer #(.N(4), .DW(32), .AW(32), .SKEW(0), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .load_valid(load_valid[2]), .in_res(in_res[2]),
        .load_ready(load_ready[2]), .tile_full(tile_full[2]), .acc_go(acc_go[2]),
        .acc_first(acc_first[2]), .out_start(out_start[2]), .out_clear(out_clear[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_res(res2),
        .out_last(out_last[2]), .busy(busy[2]), .cmd_err(cmd_err[2]));

    output_accum_tile_buffer #(.N(4), .DW(32), .AW(32), .SKEW(0), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .load_valid(load_valid[3]), .in_res(in_res[3]),
        .load_ready(load_ready[3]), .tile_full(tile_full[3]), .acc_go(acc_go[3]),
        .acc_first(acc_first[3]), .out_start(out_start[3]), .out_clear(out_clear[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_res(res3),
        .out_last(out_last[3]), .busy(busy[3]), .cmd_err(cmd_err[3]));

    typedef struct {
        logic [159:0] res;
        logic         last;
    } exp_t;

    exp_t        sb [$];
    int          n_total = 0;
    int          n_bad   = 0;
    longint      m_stage [4][4][4];
    longint      m_acc   [4][4][4];
    logic [31:0] tile    [4][4];

    function automatic int aw_of(int d);
        return (d < 2) ? 40 : 32;
    endfunction

    function automatic bit sat_of(int d);
        return d != 3;
    endfunction

    function automatic bit skew_of(int d);
        return d == 1;
    endfunction

    function automatic logic [159:0] get_res(int d);
        case (d)
            0:       return res0;
            1:       return res1;
            2:       return {32'd0, res2};
            default: return {32'd0, res3};
        endcase
    endfunction

    function automatic longint fold(longint a, longint s, bit first, int aw, bit sat);
        longint sum, hi, lo;
        if (first) return s;
        sum = a + s;
        hi  = (longint'(1) <<< (aw - 1)) - 1;
        lo  = -hi - 1;
        if (sat) begin
            if (sum > hi) return hi;
            if (sum < lo) return lo;
            return sum;
        end
        if (sum > hi) sum -= (longint'(1) <<< aw);
        if (sum < lo) sum += (longint'(1) <<< aw);
        return sum;
    endfunction

    function automatic logic [159:0] exp_row(int d, int r);
        logic [159:0] row, v, m;
        int aw;
        aw  = aw_of(d);
        row = '0;
        m   = (160'd1 << aw) - 160'd1;
        for (int c = 0; c < 4; c++) begin
            v   = {{96{m_acc[d][r][c][63]}}, m_acc[d][r][c]};
            row = row | ((v & m) << (c * aw));
        end
        return row;
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill_tile(input int kind);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kind == 0) tile[r][c] = 32'(4 * r + c + 1);
                else           tile[r][c] = (r < 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endtask

    // Drives one full tile; SKEW instances get junk outside the diagonal.
    task automatic load_tile(input int d, input bit gap, input bit collide);
        int nb;
        nb = skew_of(d) ? 7 : 4;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            chk("load_ready", load_ready[d], 1'b1);
            if (collide && b == 1) begin
                chk("load_start_err", cmd_err[d], 1'b1);
                out_start[d] = 1'b0;
            end
            load_valid[d] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (skew_of(d))
                    in_res[d][c*32 +: 32] = (b - c >= 0 && b - c < 4) ? tile[b-c][c] : 32'hDEAD_BEEF;
                else
                    in_res[d][c*32 +: 32] = tile[b][c];
            end
            if (collide && b == 0) out_start[d] = 1'b1;
            if (gap && b == 1) begin
                @(negedge clk);
                load_valid[d] = 1'b0;
                in_res[d]     = '1;
            end
        end
        @(negedge clk);
        load_valid[d] = 1'b0;
        chk("tile_full", tile_full[d], 1'b1);
        chk("full_not_ready", load_ready[d], 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m_stage[d][r][c] = longint'($signed(tile[r][c]));
    endtask

    task automatic commit(input int d, input bit first, input bit collide);
        @(negedge clk);
        acc_go[d]    = 1'b1;
        acc_first[d] = first;
        if (collide) out_start[d] = 1'b1;
        @(negedge clk);
        acc_go[d] = 1'b0;
        chk("acc_busy", busy[d], 1'b1);
        chk("acc_not_full", tile_full[d], 1'b0);
        if (collide) begin
            chk("acc_start_err", cmd_err[d], 1'b1);
            chk("acc_no_drain", out_valid[d], 1'b0);
            out_start[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("acc_busy_last", busy[d], 1'b1);
        @(negedge clk);
        chk("acc_done_busy", busy[d], 1'b0);
        chk("acc_done_ready", load_ready[d], 1'b1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m_acc[d][r][c] = fold(m_acc[d][r][c], m_stage[d][r][c], first, aw_of(d), sat_of(d));
    endtask

    task automatic drain(input int d, input bit clear, input logic [6:0] pat, input int plen,
                         input bit poke, input int exp_cycles);
        exp_t         e;
        logic [159:0] mask;
        int           k;
        bit           rdy;
        mask = (160'd1 << (4 * aw_of(d))) - 160'd1;
        @(negedge clk);
        out_start[d] = 1'b1;
        out_clear[d] = clear;
        for (int r = 0; r < 4; r++) begin
            e.res  = exp_row(d, r);
            e.last = (r == 3);
            sb.push_back(e);
        end
        if (clear)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m_acc[d][r][c] = 0;
        @(negedge clk);
        out_start[d] = 1'b0;
        out_clear[d] = 1'b0;
        k = 0;
        while (sb.size() > 0 && k < 40) begin
            rdy          = pat[k % plen];
            out_ready[d] = rdy;
            if (poke && k == 1) begin
                load_valid[d] = 1'b1;
                in_res[d]     = '1;
                chk("drain_load_ready", load_ready[d], 1'b0);
            end
            if (poke && k == 2) begin
                chk("drain_load_err", cmd_err[d], 1'b1);
                load_valid[d] = 1'b0;
            end
            chk("out_valid", out_valid[d], 1'b1);
            e = sb[0];
            chk("out_res", get_res(d) & mask, e.res);
            chk("out_last", out_last[d], e.last);
            if (rdy) void'(sb.pop_front());
            k++;
            @(negedge clk);
        end
        out_ready[d]  = 1'b0;
        load_valid[d] = 1'b0;
        if (sb.size() > 0) begin
            chk("drain_timeout", 160'(sb.size()), 160'd0);
            sb.delete();
        end
        if (exp_cycles > 0) chk("drain_cycles", 160'(k), 160'(exp_cycles));
        chk("drain_end_busy", busy[d], 1'b0);
        chk("drain_end_valid", out_valid[d], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            in_res[d] = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    m_acc[d][r][c]   = 0;
                    m_stage[d][r][c] = 0;
                end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_load_ready", load_ready[d], 1'b1);
            chk("rst_tile_full", tile_full[d], 1'b0);
            chk("rst_busy", busy[d], 1'b0);
            chk("rst_out_valid", out_valid[d], 1'b0);
            chk("rst_out_last", out_last[d], 1'b0);
            chk("rst_cmd_err", cmd_err[d], 1'b0);
            chk("rst_out_res", get_res(d), 160'd0);
        end

        // Plain capture with a gap, overwrite, full-rate drain.
        fill_tile(0);
        load_tile(0, 1'b1, 1'b0);
        commit(0, 1'b1, 1'b0);
        drain(0, 1'b0, 7'h7F, 7, 1'b0, 4);

        // Two more adds (first one also collides with out_start), clearing drain, then empty drain.
        load_tile(0, 1'b0, 1'b1);
        commit(0, 1'b0, 1'b1);
        load_tile(0, 1'b0, 1'b0);
        commit(0, 1'b0, 1'b0);
        drain(0, 1'b1, 7'h7F, 7, 1'b0, 4);
        drain(0, 1'b0, 7'h7F, 7, 1'b0, 4);

        // Diagonal capture must reproduce the plain tile.
        load_tile(1, 1'b1, 1'b0);
        commit(1, 1'b1, 1'b0);
        drain(1, 1'b0, 7'h7F, 7, 1'b0, 4);

        // Extremes added to themselves: clamp versus wrap.
        fill_tile(1);
        for (int d = 2; d < 4; d++) begin
            load_tile(d, 1'b0, 1'b0);
            commit(d, 1'b1, 1'b0);
            load_tile(d, 1'b0, 1'b0);
            commit(d, 1'b0, 1'b0);
            drain(d, 1'b0, 7'h7F, 7, 1'b0, 4);
        end

        // Back-pressured drain with a stray load beat.
        fill_tile(0);
        load_tile(0, 1'b0, 1'b0);
        commit(0, 1'b1, 1'b0);
        drain(0, 1'b0, 7'b1011001, 7, 1'b1, 7);
        drain(0, 1'b0, 7'h7F, 7, 1'b0, 4);

        // Reset in the middle of accumulation.
        load_tile(0, 1'b0, 1'b0);
        @(negedge clk);
        acc_go[0]    = 1'b1;
        acc_first[0] = 1'b0;
        @(negedge clk);
        acc_go[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_ready", load_ready[0], 1'b1);
        for (int d = 0; d < 4; d++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    m_acc[d][r][c]   = 0;
                    m_stage[d][r][c] = 0;
                end
        drain(0, 1'b0, 7'h7F, 7, 1'b0, 4);
        drain(1, 1'b0, 7'h7F, 7, 1'b0, 4);

        // acc_go while idle is rejected without moving the FSM.
        @(negedge clk);
        acc_go[0]    = 1'b1;
        acc_first[0] = 1'b1;
        @(negedge clk);
        acc_go[0] = 1'b0;
        chk("idle_go_err", cmd_err[0], 1'b1);
        chk("idle_go_busy", busy[0], 1'b0);
        @(negedge clk);
        chk("idle_go_err_pulse", cmd_err[0], 1'b0);
        chk("idle_go_still_idle", load_ready[0], 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/output_accum_tile_buffer.md
# output_accum_tile_buffer

Parametrised output stage for the N×N systolic array. Captures one result tile per pass (row-parallel or diagonally skewed), then folds it into a signed accumulator tile over N cycles, with optional saturation. Drains the accumulated tile row by row over a valid/ready stream. Sits between the PE array result bus and the writeback path, and supports multi-pass K-dimension accumulation.

## Interface
- N, default 4: array dimension; tile is N×N, bus is N lanes.
- DW, default 32: input lane width, signed two's complement.
- AW, default 40: accumulator/output lane width, signed; AW >= DW.
- SKEW, default 0: 0 = row-parallel capture (N beats); 1 = diagonal de-skew capture (2N-1 beats).
- SAT, default 1: 1 = saturate on accumulate; 0 = wrap modulo 2^AW.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  capture beat present on in_res.
- in_res  in  N*DW  lane c = in_res[c*DW +: DW].
- load_ready  out  1  beat accepted this cycle (state IDLE or LOAD).
- tile_full  out  1  staging tile complete (state FULL).
- acc_go  in  1  pulse: fold staging tile into accumulator.
- acc_first  in  1  sampled with acc_go: 1 = overwrite, 0 = add.
- out_start  in  1  pulse: begin draining accumulator tile.
- out_clear  in  1  sampled with out_start: clear accumulator after last beat.
- out_valid  out  1  out_res holds a valid row.
- out_ready  in  1  downstream accepts row.
- out_res  out  N*AW  lane c = out_res[c*AW +: AW].
- out_last  out  1  current row is row N-1.
- busy  out  1  state != IDLE.
- cmd_err  out  1  one-cycle pulse on an ignored command or dropped beat.

## Operation
- States: IDLE, LOAD, FULL, ACC, DRAIN.
- IDLE: load_valid=1 → beat 0 captured, LOAD, or FULL if total beats = 1 (N=1, SKEW=0). out_start → DRAIN. acc_go in IDLE → cmd_err.
- LOAD: each beat with load_valid=1 increments beat counter b; gaps allowed. After the last beat (b = N-1 for SKEW=0, 2N-2 for SKEW=1) → FULL.
- Capture, SKEW=0: beat b writes staging row b, all lanes.
- Capture, SKEW=1: beat b, lane c writes staging row b-c only when 0 <= b-c < N; other lanes ignored.
- FULL: load_ready=0, tile_full=1. acc_go → ACC; acc_first latched.
- ACC: exactly N cycles; cycle r processes row r. acc[r][c] = sext(stage[r][c]) if first, else acc[r][c] + sext(stage[r][c]). Then → IDLE; beat counter cleared.
- Arithmetic: sum formed at AW+1 bits. SAT=1 clamps to [-2^(AW-1), 2^(AW-1)-1]. SAT=0 keeps the low AW bits.
- DRAIN: row pointer p starts at 0. out_res = acc[p], out_valid=1. p advances on out_valid&out_ready. On the row N-1 handshake → IDLE; if out_clear was latched, all acc = 0 on that same edge.
- Ignored with cmd_err: load_valid when load_ready=0; acc_go outside FULL; out_start outside IDLE. If acc_go and out_start occur together, acc_go has priority in FULL, and out_start raises cmd_err.
- load_valid and out_start together in IDLE: the load beat wins and out_start raises cmd_err.

## Timing
- Reset: state IDLE, counters 0, staging and accumulator tiles 0, all outputs 0 except load_ready=1.
- load_ready is combinational from state; a beat counts on the edge where load_valid&load_ready.
- tile_full asserts the cycle after the last beat's edge.
- acc_go at edge T: ACC for cycles T+1..T+N; busy drops and load_ready rises at T+N+1.
- Row r is written at the end of ACC cycle r. A drain starting after ACC sees the updated values.
- out_start at edge T: out_valid=1 from T+1, registered. out_res and out_last stay stable while out_valid&!out_ready. Minimum drain is N cycles.
- Back-to-back: a new load beat may be presented in the first IDLE cycle after ACC or DRAIN.
- rst mid-operation aborts any state in one edge. Partial staging and accumulator contents are discarded (zeroed).

## Test plan
- N=4, SKEW=0: 4 beats with row r lane c = 4r+c+1; acc_go with acc_first=1; drain with out_ready=1 → rows {1,2,3,4}…{13,14,15,16}, out_last on row 3, 4 cycles.
- Same tile committed 3× (acc_first=1, then 0, 0), then drain with out_clear=1 → values 3×(4r+c+1). A second drain → all zeros.
- SKEW=1, 7 beats: lane c = 4(b-c)+c+1 inside the diagonal, 0xDEADBEEF outside → drain identical to the first scenario; junk values never appear.
- AW=DW=32, SAT=1: 0x7FFFFFFF committed twice → 0x7FFFFFFF; 0x80000000 twice → 0x80000000. With SAT=0 → 0xFFFFFFFE and 0x00000000.
- Drain with out_ready pattern 1,0,0,1,1,0,1 → out_res held during stalls, 4 handshakes, out_last only on the 4th. load_valid during DRAIN → cmd_err=1, load_ready=0, tile unchanged.
- rst asserted at ACC cycle 2 → next cycle IDLE, busy=0. A subsequent drain → all zeros. acc_go in IDLE → cmd_err pulse, no state change.
